// File: rtl/led_pkg.sv
// Shared constants and types for the LED matrix frame receiver.
package led_pkg;

  localparam logic [15:0] DEF_ETH_TYPE  = 16'h88B5;
  localparam logic [47:0] DEF_LOCAL_MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BCAST_MAC     = 48'hFFFF_FFFF_FFFF;

  localparam int unsigned FLAG_EOF_BIT = 0;

  typedef logic [23:0] rgb_t;

  typedef enum logic [2:0] {
    StIdle,
    StFlags,
    StRow,
    StPix,
    StTail,
    StDrop
  } rx_state_e;

endpackage

// File: rtl/led_frame_rx.sv
// Filters Ethernet frames by type/destination and unpacks one matrix row of RGB pixels
// per packet into the frame buffer write port.
module led_frame_rx
  import led_pkg::*;
#(
  parameter logic [15:0] ETH_TYPE   = DEF_ETH_TYPE,
  parameter logic [47:0] LOCAL_MAC  = DEF_LOCAL_MAC,
  parameter int unsigned ROWS       = 32,
  parameter int unsigned COLS       = 64,
  parameter int unsigned ADDR_WIDTH = 11
) (
  input  logic                  clk,
  input  logic                  rst,

  input  logic                  s_eth_hdr_valid,
  output logic                  s_eth_hdr_ready,
  input  logic [47:0]           s_eth_dest_mac,
  input  logic [15:0]           s_eth_type,

  input  logic [7:0]            s_eth_payload_axis_tdata,
  input  logic                  s_eth_payload_axis_tvalid,
  output logic                  s_eth_payload_axis_tready,
  input  logic                  s_eth_payload_axis_tlast,
  input  logic                  s_eth_payload_axis_tuser,

  output logic                  fb_wr_en,
  output logic [ADDR_WIDTH-1:0] fb_wr_addr,
  output logic [23:0]           fb_wr_data,

  output logic                  frame_done,
  output logic [15:0]           pkt_good_count,
  output logic [15:0]           pkt_drop_count
);

  localparam int unsigned ColW     = (COLS > 1) ? $clog2(COLS) : 1;
  localparam logic [ColW-1:0] LastCol = ColW'(COLS - 1);
  localparam bit          ColsPow2 = ((COLS & (COLS - 1)) == 0);
  localparam int unsigned ColShift = $clog2(COLS);

  rx_state_e             state_q, state_d;
  logic                  eof_q, eof_d;
  logic [7:0]            row_q, row_d;
  logic [ColW-1:0]       col_q, col_d;
  logic [1:0]            byte_idx_q, byte_idx_d;
  logic [7:0]            r_q, r_d;
  logic [7:0]            g_q, g_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  rgb_t                  wr_data_q, wr_data_d;
  logic                  done_q, done_d;
  logic [15:0]           good_q, good_d;
  logic [15:0]           drop_q, drop_d;

  logic                  beat;
  logic                  hdr_ok;
  logic                  last_px;
  logic [ADDR_WIDTH-1:0] pix_addr;

  assign s_eth_hdr_ready           = (state_q == StIdle);
  assign s_eth_payload_axis_tready = (state_q != StIdle);
  assign beat = s_eth_payload_axis_tvalid && s_eth_payload_axis_tready;

  assign hdr_ok = (s_eth_type == ETH_TYPE) &&
                  ((s_eth_dest_mac == LOCAL_MAC) || (s_eth_dest_mac == BCAST_MAC));

  // Current byte is the B byte of the last column.
  assign last_px = (byte_idx_q == 2'd2) && (col_q == LastCol);

  always_comb begin
    if (ColsPow2) begin
      pix_addr = (ADDR_WIDTH'(row_q) << ColShift) + ADDR_WIDTH'(col_q);
    end else begin
      pix_addr = ADDR_WIDTH'(row_q) * ADDR_WIDTH'(COLS) + ADDR_WIDTH'(col_q);
    end
  end

  always_comb begin
    state_d    = state_q;
    eof_d      = eof_q;
    row_d      = row_q;
    col_d      = col_q;
    byte_idx_d = byte_idx_q;
    r_d        = r_q;
    g_d        = g_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    done_d     = 1'b0;
    good_d     = good_q;
    drop_d     = drop_q;

    unique case (state_q)
      StIdle: begin
        if (s_eth_hdr_valid) begin
          state_d = hdr_ok ? StFlags : StDrop;
        end
      end

      StFlags: begin
        if (beat) begin
          eof_d = s_eth_payload_axis_tdata[FLAG_EOF_BIT];
          if (s_eth_payload_axis_tlast) begin
            state_d = StIdle;
            drop_d  = drop_q + 16'd1;
          end else begin
            state_d = StRow;
          end
        end
      end

      StRow: begin
        if (beat) begin
          row_d      = s_eth_payload_axis_tdata;
          col_d      = '0;
          byte_idx_d = 2'd0;
          if (s_eth_payload_axis_tlast) begin
            state_d = StIdle;
            drop_d  = drop_q + 16'd1;
          end else if ({24'd0, s_eth_payload_axis_tdata} >= ROWS) begin
            state_d = StDrop;
          end else begin
            state_d = StPix;
          end
        end
      end

      StPix: begin
        if (beat) begin
          case (byte_idx_q)
            2'd0: begin
              r_d        = s_eth_payload_axis_tdata;
              byte_idx_d = 2'd1;
            end
            2'd1: begin
              g_d        = s_eth_payload_axis_tdata;
              byte_idx_d = 2'd2;
            end
            default: begin
              wr_en_d    = 1'b1;
              wr_addr_d  = pix_addr;
              wr_data_d  = {r_q, g_q, s_eth_payload_axis_tdata};
              byte_idx_d = 2'd0;
              col_d      = col_q + 1'b1;
            end
          endcase
          if (s_eth_payload_axis_tlast) begin
            state_d = StIdle;
            if (last_px && !s_eth_payload_axis_tuser) begin
              good_d = good_q + 16'd1;
              done_d = eof_q;
            end else begin
              drop_d = drop_q + 16'd1;
            end
          end else if (last_px) begin
            state_d = StTail;
          end
        end
      end

      StTail: begin
        if (beat && s_eth_payload_axis_tlast) begin
          state_d = StIdle;
          if (s_eth_payload_axis_tuser) begin
            drop_d = drop_q + 16'd1;
          end else begin
            good_d = good_q + 16'd1;
            done_d = eof_q;
          end
        end
      end

      StDrop: begin
        if (beat && s_eth_payload_axis_tlast) begin
          state_d = StIdle;
          drop_d  = drop_q + 16'd1;
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      eof_q      <= 1'b0;
      row_q      <= '0;
      col_q      <= '0;
      byte_idx_q <= 2'd0;
      r_q        <= '0;
      g_q        <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      done_q     <= 1'b0;
      good_q     <= '0;
      drop_q     <= '0;
    end else begin
      state_q    <= state_d;
      eof_q      <= eof_d;
      row_q      <= row_d;
      col_q      <= col_d;
      byte_idx_q <= byte_idx_d;
      r_q        <= r_d;
      g_q        <= g_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      done_q     <= done_d;
      good_q     <= good_d;
      drop_q     <= drop_d;
    end
  end

  assign fb_wr_en       = wr_en_q;
  assign fb_wr_addr     = wr_addr_q;
  assign fb_wr_data     = wr_data_q;
  assign frame_done     = done_q;
  assign pkt_good_count = good_q;
  assign pkt_drop_count = drop_q;

endmodule

// File: doc/led_frame_rx.md
# led_frame_rx

Consumes the parsed Ethernet header and payload stream from the MAC receive path. Filters frames by EtherType and destination MAC, and decodes a row-oriented pixel packet. Writes 24-bit RGB pixels into the LED matrix frame buffer write port, and signals frame completion to the display scan logic. Runs entirely in the `clk_125` logic domain, directly downstream of the Ethernet header parser.

## Interface
- `ETH_TYPE`, 16'h88B5: accepted EtherType.
- `LOCAL_MAC`, 48'h02_00_00_00_00_01: accepted unicast destination; broadcast FF:FF:FF:FF:FF:FF is also accepted.
- `ROWS`, 32: matrix rows.
- `COLS`, 64: matrix columns, i.e. pixels per packet.
- `ADDR_WIDTH`, 11: frame buffer address width, ≥ clog2(ROWS*COLS).
- `clk` in 1: logic clock.
- `rst` in 1: synchronous, active-high reset.
- `s_eth_hdr_valid` in 1, `s_eth_hdr_ready` out 1: header handshake.
- `s_eth_dest_mac` in 48, `s_eth_type` in 16: header fields.
- `s_eth_payload_axis_tdata` in 8, `_tvalid` in 1, `_tready` out 1, `_tlast` in 1, `_tuser` in 1: payload stream; tuser marks a bad frame.
- `fb_wr_en` out 1, `fb_wr_addr` out ADDR_WIDTH, `fb_wr_data` out 24 ({R,G,B}): frame buffer write port.
- `frame_done` out 1: one-cycle pulse.
- `pkt_good_count` out 16, `pkt_drop_count` out 16: status, wrapping.

## Operation
- Payload format:
  - byte0 is flags; bit0 = end-of-frame, other bits ignored.
  - byte1 is the row index.
  - Then COLS×3 bytes, ordered R,G,B per pixel, column 0 first.
- FSM states:
  - IDLE: `s_eth_hdr_ready`=1. On header handshake, go to FLAGS if type==ETH_TYPE and dest is LOCAL_MAC or broadcast; otherwise go to DROP.
  - FLAGS: latch byte0, go to ROW.
  - ROW: latch byte1. If row ≥ ROWS, go to DROP; otherwise go to PIX with col=0, byte_idx=0.
  - PIX: accumulate bytes. On each third byte, write the pixel at address row*COLS+col, then col++. After col reaches COLS, go to TAIL.
  - TAIL: discard extra bytes until tlast.
  - DROP: discard bytes until tlast, then go to IDLE and increment `pkt_drop_count`.
- `s_eth_payload_axis_tready`=1 in every state except IDLE.
- tlast in FLAGS, ROW, or PIX before all COLS pixels are written (truncated packet):
  - Go to IDLE and increment drop count; no `frame_done`.
  - Pixels already written stay written. No partial pixel is written.
- tlast with tuser=1 in any state: count as a drop, no `frame_done`.
- tlast in TAIL, or on the final pixel byte, with tuser=0: count as good, and pulse `frame_done` if flags bit0=1.
- The address multiply uses constant COLS. Use shift-add when COLS is a power of two; width is ADDR_WIDTH with no overflow for legal rows.
- Counters wrap from 16'hFFFF to 0.
- Reset mid-packet: FSM goes to IDLE and all outputs take reset values. The remainder of the in-flight payload is then handled by the upstream parser; this block does not resynchronise beyond IDLE.

## Timing
- Reset values:
  - `s_eth_hdr_ready`=1, `s_eth_payload_axis_tready`=0.
  - `fb_wr_en`=0, `fb_wr_addr`=0, `fb_wr_data`=0.
  - `frame_done`=0, counters=0.
- Header handshake in cycle N: tready=1 from cycle N+1.
- Pixel write: `fb_wr_en` is asserted for exactly one cycle, the cycle after the B byte is accepted; address and data are registered alongside it.
- `frame_done` and counter updates occur the cycle after the tlast beat is accepted, coincident with any final-pixel `fb_wr_en`.
- Back-to-back packets: a new header is accepted the cycle after the FSM returns to IDLE, with a minimum 1-cycle gap.
- Payload stalls (tvalid=0) leave all state unchanged.

## Structure
- Package `led_pkg`:
  - Default ETH_TYPE and LOCAL_MAC.
  - Flags bit index.
  - Pixel type `rgb_t` (24-bit).
  - FSM state enum.
- No sub-module needed. Pixel byte assembly is a 2-bit byte_idx plus two 8-bit holding registers, kept inline.

## Test plan
- Good packet: dest=LOCAL_MAC, type 88B5, flags=01, row=3, 192 bytes. Expect 64 writes at addresses 192..255 with data from the payload, `frame_done` pulse, good=1.
- Wrong type 0800: expect no writes, drop=1, tready held until tlast.
- Row=32 (out of range): expect no writes, drop=1.
- Truncated at 100 payload bytes after header: expect 33 writes at addresses starting row*64, no pixel 33, drop=1, no `frame_done`.
- 200-byte payload with tuser=1 on tlast: expect 64 writes, extra bytes discarded, drop=1, no `frame_done`.
- Random tvalid gaps with broadcast dest, flags=00: expect identical writes to the gap-free case, good=1, no `frame_done`; assert reset mid-PIX and check all outputs return to reset values next cycle.
